fetch_stage: RTL and testbench

Instruction fetch stage of the vector ASIP pipeline, directly upstream of the decoder stage. It owns the program counter and drives a synchronous-read instruction memory. Its IF/ID output register delivers the 16-bit instruction, its PC and a valid flag to the decoder. The stage supports stall (PC write enable), branch redirect with squash, and a halt state entered on a HALT opcode.

---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: redirect/stall controls, instruction-memory port and IF/ID outputs.
interface fetch_stage_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16
);
  logic                   pc_write_en;
  logic                   branch_taken;
  logic [ADDR_WIDTH-1:0]  branch_target;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   instr_valid;
  logic                   halted;

  modport master (
    input  pc_write_en, branch_taken, branch_target, imem_rdata,
    output imem_addr, instruction, instr_pc, instr_valid, halted
  );

  modport slave (
    output pc_write_en, branch_taken, branch_target, imem_rdata,
    input  imem_addr, instruction, instr_pc, instr_valid, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read imem, feeds the IF/ID register.
//   state  | meaning
//   RUN    | fetching; advances on pc_write_en, redirects on branch_taken
//   HALTED | HALT latched; only a branch or reset leaves this state
module fetch_stage #(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    INSTR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [3:0]            HALT_OPCODE = 4'hF
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master fs
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t                 state, stateD;
  logic [ADDR_WIDTH-1:0]  pcQ, pcD;
  logic [ADDR_WIDTH-1:0]  reqPcQ, reqPcD;
  logic                   reqValidQ, reqValidD;
  logic [INSTR_WIDTH-1:0] instrQ, instrD;
  logic [ADDR_WIDTH-1:0]  instrPcQ, instrPcD;
  logic                   instrValidQ, instrValidD;
  logic                   haltedQ, haltedD;
  logic [ADDR_WIDTH-1:0]  addr;
  logic                   isHalt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      pcQ         <= RESET_PC;
      reqPcQ      <= RESET_PC;
      reqValidQ   <= 1'b0;
      instrQ      <= '0;
      instrPcQ    <= '0;
      instrValidQ <= 1'b0;
      haltedQ     <= 1'b0;
    end else begin
      state       <= stateD;
      pcQ         <= pcD;
      reqPcQ      <= reqPcD;
      reqValidQ   <= reqValidD;
      instrQ      <= instrD;
      instrPcQ    <= instrPcD;
      instrValidQ <= instrValidD;
      haltedQ     <= haltedD;
    end
  end

  assign isHalt = reqValidQ && (fs.imem_rdata[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);

  always_comb begin
    stateD      = state;
    pcD         = pcQ;
    reqPcD      = reqPcQ;
    reqValidD   = reqValidQ;
    instrD      = instrQ;
    instrPcD    = instrPcQ;
    instrValidD = instrValidQ;
    // halted lags the HALTED state by one edge so the HALT word is seen valid first
    haltedD     = (state == HALTED);
    // default re-issues the in-flight address so its data survives a stall
    addr        = reqPcQ;

    if (fs.branch_taken) begin
      addr        = fs.branch_target;
      reqPcD      = fs.branch_target;
      reqValidD   = 1'b1;
      pcD         = fs.branch_target + 1'b1;
      instrValidD = 1'b0;
      stateD      = RUN;
      haltedD     = 1'b0;
    end else if (state == HALTED) begin
      instrValidD = 1'b0;
    end else if (fs.pc_write_en) begin
      addr        = pcQ;
      instrD      = fs.imem_rdata;
      instrPcD    = reqPcQ;
      instrValidD = reqValidQ;
      reqPcD      = pcQ;
      if (isHalt) begin
        stateD    = HALTED;
        reqValidD = 1'b0;
      end else begin
        reqValidD = 1'b1;
        pcD       = pcQ + 1'b1;
      end
    end
  end

  assign fs.imem_addr   = addr;
  assign fs.instruction = instrQ;
  assign fs.instr_pc    = instrPcQ;
  assign fs.instr_valid = instrValidQ;
  assign fs.halted      = haltedQ;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: vector table for stream/stall/branch/reset, hand sequences for HALT and PC wrap.
module tb_fetch_stage;

  typedef struct {
    logic        rst;
    logic        we;
    logic        br;
    logic [7:0]  tgt;
    int          mode;    // 0 none, 1 valid+halted, 2 valid+halted+pc+instr
    logic        eValid;
    logic [7:0]  ePc;
    logic [15:0] eInstr;
    logic        eHalt;
    logic        chkAddr;
    logic [7:0]  eAddr;
  } vec_t;

  logic clk;
  logic rstA, rstB;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] memA [256];
  logic [15:0] memB [256];

  fetch_stage_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) ifA ();
  fetch_stage_if #(.ADDR_WIDTH(8), .INSTR_WIDTH(16)) ifB ();

  fetch_stage #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00), .HALT_OPCODE(4'hF))
    dutA (.clk(clk), .reset(rstA), .fs(ifA));
  fetch_stage #(.ADDR_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'hFE), .HALT_OPCODE(4'hF))
    dutB (.clk(clk), .reset(rstB), .fs(ifB));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    ifA.imem_rdata <= memA[ifA.imem_addr];
    ifB.imem_rdata <= memB[ifB.imem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rst, logic we, logic br, logic [7:0] tgt, int mode,
                              logic ev, logic [7:0] epc, logic [15:0] ei, logic eh,
                              logic ca, logic [7:0] ea);
    vec_t v;
    v.rst = rst; v.we = we; v.br = br; v.tgt = tgt; v.mode = mode;
    v.eValid = ev; v.ePc = epc; v.eInstr = ei; v.eHalt = eh; v.chkAddr = ca; v.eAddr = ea;
    return v;
  endfunction

  task automatic tickA(input logic rst, input logic we, input logic br, input logic [7:0] tgt);
    @(negedge clk);
    rstA = rst;
    ifA.pc_write_en = we;
    ifA.branch_taken = br;
    ifA.branch_target = tgt;
    #1;
  endtask

  task automatic expA(input string nm, input logic ev, input logic [7:0] epc,
                      input logic [15:0] ei, input logic eh, input logic full);
    chk({nm, " valid"}, 32'(ifA.instr_valid), 32'(ev));
    chk({nm, " halted"}, 32'(ifA.halted), 32'(eh));
    if (full) begin
      chk({nm, " pc"}, 32'(ifA.instr_pc), 32'(epc));
      chk({nm, " instr"}, 32'(ifA.instruction), 32'(ei));
    end
  endtask

  task automatic expB(input string nm, input logic ev, input logic [7:0] epc, input logic [15:0] ei);
    chk({nm, " valid"}, 32'(ifB.instr_valid), 32'(ev));
    chk({nm, " pc"}, 32'(ifB.instr_pc), 32'(epc));
    chk({nm, " instr"}, 32'(ifB.instruction), 32'(ei));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[24];

    for (int i = 0; i < 256; i++) begin
      memA[i] = 16'h1000 + 16'(i);
      memB[i] = 16'h1000 + 16'(i);
    end
    rstA = 1'b0; rstB = 1'b0;
    ifA.pc_write_en = 1'b1; ifA.branch_taken = 1'b0; ifA.branch_target = 8'h00;
    ifB.pc_write_en = 1'b1; ifB.branch_taken = 1'b0; ifB.branch_target = 8'h00;

    //             rst we br tgt   mode ev pc     instr     h  ca addr
    vecs[0]  = mk(0, 1, 0, 8'h00, 0, 0, 8'h00, 16'h0000, 0, 0, 8'h00);
    vecs[1]  = mk(1, 1, 0, 8'h00, 2, 0, 8'h00, 16'h0000, 0, 1, 8'h00);
    vecs[2]  = mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 1, 8'h01);
    vecs[3]  = mk(1, 1, 0, 8'h00, 2, 1, 8'h00, 16'h1000, 0, 1, 8'h02);
    vecs[4]  = mk(1, 1, 0, 8'h00, 2, 1, 8'h01, 16'h1001, 0, 0, 8'h00);
    vecs[5]  = mk(1, 1, 0, 8'h00, 2, 1, 8'h02, 16'h1002, 0, 0, 8'h00);
    vecs[6]  = mk(1, 1, 0, 8'h00, 2, 1, 8'h03, 16'h1003, 0, 0, 8'h00);
    vecs[7]  = mk(1, 1, 0, 8'h00, 2, 1, 8'h04, 16'h1004, 0, 0, 8'h00);
    vecs[8]  = mk(1, 0, 0, 8'h00, 2, 1, 8'h05, 16'h1005, 0, 1, 8'h06);
    vecs[9]  = mk(1, 0, 0, 8'h00, 2, 1, 8'h05, 16'h1005, 0, 1, 8'h06);
    vecs[10] = mk(1, 0, 0, 8'h00, 2, 1, 8'h05, 16'h1005, 0, 1, 8'h06);
    vecs[11] = mk(1, 1, 0, 8'h00, 2, 1, 8'h05, 16'h1005, 0, 1, 8'h07);
    vecs[12] = mk(1, 1, 0, 8'h00, 2, 1, 8'h06, 16'h1006, 0, 1, 8'h08);
    vecs[13] = mk(1, 1, 1, 8'h40, 2, 1, 8'h07, 16'h1007, 0, 1, 8'h40);
    vecs[14] = mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 1, 8'h41);
    vecs[15] = mk(1, 1, 0, 8'h00, 2, 1, 8'h40, 16'h1040, 0, 1, 8'h42);
    vecs[16] = mk(1, 0, 1, 8'h20, 2, 1, 8'h41, 16'h1041, 0, 1, 8'h20);
    vecs[17] = mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 1, 8'h21);
    vecs[18] = mk(1, 1, 0, 8'h00, 2, 1, 8'h20, 16'h1020, 0, 0, 8'h00);
    vecs[19] = mk(0, 1, 0, 8'h00, 2, 1, 8'h21, 16'h1021, 0, 0, 8'h00);
    vecs[20] = mk(1, 1, 0, 8'h00, 2, 0, 8'h00, 16'h0000, 0, 1, 8'h00);
    vecs[21] = mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 16'h0000, 0, 0, 8'h00);
    vecs[22] = mk(1, 1, 0, 8'h00, 2, 1, 8'h00, 16'h1000, 0, 0, 8'h00);
    vecs[23] = mk(1, 1, 0, 8'h00, 2, 1, 8'h01, 16'h1001, 0, 0, 8'h00);

    for (int i = 0; i < 24; i++) begin
      tickA(vecs[i].rst, vecs[i].we, vecs[i].br, vecs[i].tgt);
      if (vecs[i].mode >= 1)
        expA($sformatf("v%0d", i), vecs[i].eValid, vecs[i].ePc, vecs[i].eInstr,
             vecs[i].eHalt, vecs[i].mode == 2);
      if (vecs[i].chkAddr)
        chk($sformatf("v%0d imem_addr", i), 32'(ifA.imem_addr), 32'(vecs[i].eAddr));
    end

    // HALT at address 4, reset while halted, halt again, leave via branch
    memA[4] = 16'hF000;
    tickA(0, 1, 0, 8'h00);
    repeat (6) tickA(1, 1, 0, 8'h00);
    tickA(1, 1, 0, 8'h00);
    expA("halt latch", 1, 8'h04, 16'hF000, 0, 1);
    tickA(1, 0, 0, 8'h00);
    expA("halted rise", 0, 8'h00, 16'h0000, 1, 0);
    tickA(1, 1, 0, 8'h00);
    expA("halted hold", 0, 8'h00, 16'h0000, 1, 0);
    tickA(0, 1, 0, 8'h00);
    tickA(1, 1, 0, 8'h00);
    expA("reset from halt", 0, 8'h00, 16'h0000, 0, 1);
    chk("reset from halt imem_addr", 32'(ifA.imem_addr), 32'h00);
    repeat (5) tickA(1, 1, 0, 8'h00);
    tickA(1, 1, 0, 8'h00);
    expA("halt relatch", 1, 8'h04, 16'hF000, 0, 1);
    tickA(1, 1, 0, 8'h00);
    expA("halted again", 0, 8'h00, 16'h0000, 1, 0);
    tickA(1, 0, 1, 8'h10);
    expA("halted branch cycle", 0, 8'h00, 16'h0000, 1, 0);
    chk("halted branch imem_addr", 32'(ifA.imem_addr), 32'h10);
    tickA(1, 1, 0, 8'h00);
    expA("unhalt bubble", 0, 8'h00, 16'h0000, 0, 0);
    tickA(1, 1, 0, 8'h00);
    expA("unhalt target", 1, 8'h10, 16'h1010, 0, 1);
    tickA(1, 1, 0, 8'h00);
    expA("unhalt next", 1, 8'h11, 16'h1011, 0, 1);

    // branch in the cycle the HALT would be latched: no halt
    tickA(0, 1, 0, 8'h00);
    repeat (5) tickA(1, 1, 0, 8'h00);
    tickA(1, 1, 1, 8'h30);
    expA("pre-halt branch", 1, 8'h03, 16'h1003, 0, 1);
    tickA(1, 1, 0, 8'h00);
    expA("squash halt bubble", 0, 8'h00, 16'h0000, 0, 0);
    tickA(1, 1, 0, 8'h00);
    expA("squash halt target", 1, 8'h30, 16'h1030, 0, 1);
    tickA(1, 1, 0, 8'h00);
    expA("squash halt next", 1, 8'h31, 16'h1031, 0, 1);

    // RESET_PC=FE wraps through FF to 00
    @(negedge clk); rstB = 1'b1; #1;
    expB("wrap reset", 0, 8'h00, 16'h0000);
    chk("wrap reset halted", 32'(ifB.halted), 32'h0);
    chk("wrap reset imem_addr", 32'(ifB.imem_addr), 32'hFE);
    @(negedge clk); #1;
    chk("wrap c1 valid", 32'(ifB.instr_valid), 32'h0);
    @(negedge clk); #1;
    expB("wrap c2", 1, 8'hFE, 16'h10FE);
    @(negedge clk); #1;
    expB("wrap c3", 1, 8'hFF, 16'h10FF);
    @(negedge clk); #1;
    expB("wrap c4", 1, 8'h00, 16'h1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
